// File: rtl/bp_btb_if.sv
// Branch target buffer bus: fetch-side lookup, EXE-side update, table clear
// and performance counter readout.
//   master : CPU pipeline side (drives lookups/updates, receives predictions)
//   slave  : BTB side
// Signals:
//   stall          front-end stall; suppresses lookup statistics
//   if_valid/if_pc fetch lookup request
//   pred_taken     predicted-taken indication (combinational)
//   pred_target    predicted target, 0 when not predicted taken
//   upd_*          resolved-branch update from EXE
//   bp_clear       invalidate every entry
//   stat_*         32-bit saturating performance counters
interface bp_btb_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  stall;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  upd_en;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    logic                  bp_clear;
    logic [31:0]           stat_lookups;
    logic [31:0]           stat_hits;
    logic [31:0]           stat_mispredicts;

    modport master (
        output stall, if_valid, if_pc,
        output upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        output bp_clear,
        input  pred_taken, pred_target,
        input  stat_lookups, stat_hits, stat_mispredicts
    );

    modport slave (
        input  stall, if_valid, if_pc,
        input  upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  bp_clear,
        output pred_taken, pred_target,
        output stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational; updates and clears land on the rising clock edge
// (read-before-write for a lookup in the same cycle).
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (clears table and statistics)
//   btb  bp_btb_if slave modport (lookup, update, clear, statistics)
// Parameters:
//   ADDR_WIDTH  PC width in bits
//   ENTRIES     number of entries, power of two, >= 2
//   CTR_WIDTH   direction counter width, 1..4
// Build option:
//   BP_BTB_STATS_EN  when defined, implements the lookup/hit/mispredict
//                    counters; otherwise the stat outputs are tied to zero.
module bp_btb #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned CTR_WIDTH  = 2
) (
    input logic     clk,
    input logic     rst,
    bp_btb_if.slave btb
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX - 2;

    localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;
    // Freshly allocated entries start weakly taken.
    localparam logic [CTR_WIDTH-1:0] CtrWeak = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    // Table storage
    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_q    [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_d    [ENTRIES];

    // Lookup path
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             hit;

    assign rd_idx = btb.if_pc[IDX+1:2];
    assign rd_tag = btb.if_pc[ADDR_WIDTH-1:IDX+2];
    assign hit    = btb.if_valid & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);

    assign btb.pred_taken  = hit & ctr_q[rd_idx][CTR_WIDTH-1];
    assign btb.pred_target = btb.pred_taken ? target_q[rd_idx] : '0;

    // Update path
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             upd_hit;

    assign wr_idx  = btb.upd_pc[IDX+1:2];
    assign wr_tag  = btb.upd_pc[ADDR_WIDTH-1:IDX+2];
    assign upd_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

    // Word-aligned PCs: the two low bits never select anything.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{btb.if_pc[1:0], btb.upd_pc[1:0]};

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (btb.bp_clear) begin
            // Clear wins over a simultaneous update; tags/targets are dead once invalid.
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = '0;
            end
        end else if (btb.upd_en) begin
            if (upd_hit) begin
                if (btb.upd_taken) begin
                    if (ctr_q[wr_idx] != CtrMax) begin
                        ctr_d[wr_idx] = ctr_q[wr_idx] + 1'b1;
                    end
                    target_d[wr_idx] = btb.upd_target;
                end else if (ctr_q[wr_idx] != '0) begin
                    ctr_d[wr_idx] = ctr_q[wr_idx] - 1'b1;
                end
            end else if (btb.upd_taken) begin
                // Miss on a taken branch: replace whatever aliases this slot.
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = btb.upd_target;
                ctr_d[wr_idx]    = CtrWeak;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_BTB_STATS_EN
    // Saturating performance counters; bp_clear leaves them alone.
    logic        cnt_lookup, cnt_hit, cnt_mispredict;
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    assign cnt_lookup     = btb.if_valid & ~btb.stall;
    assign cnt_hit        = cnt_lookup & hit;
    assign cnt_mispredict = btb.upd_en & btb.upd_mispredict;

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_hits_d        = stat_hits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (cnt_lookup && (stat_lookups_q != '1)) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end
        if (cnt_hit && (stat_hits_q != '1)) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
        if (cnt_mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign btb.stat_lookups     = stat_lookups_q;
    assign btb.stat_hits        = stat_hits_q;
    assign btb.stat_mispredicts = stat_mispredicts_q;
`else
    assign btb.stat_lookups     = '0;
    assign btb.stat_hits        = '0;
    assign btb.stat_mispredicts = '0;

    // Only the statistics consume these.
    logic unused_stat_inputs;
    assign unused_stat_inputs = ^{btb.stall, btb.upd_mispredict};
`endif

endmodule
